// File: rtl/agc_seq_pkg.sv
// Shared definitions for the AGC sequencer and the register map that exposes its state.
package agc_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE     = 3'd1;
  localparam logic [STATE_W-1:0] ST_MEAS_START = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEAS_WAIT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_CAL        = 3'd4;
  localparam logic [STATE_W-1:0] ST_HOLD       = 3'd5;

  function automatic logic is_busy(input logic [STATE_W-1:0] s);
    return (s == ST_SETTLE) || (s == ST_MEAS_START) ||
           (s == ST_MEAS_WAIT) || (s == ST_CAL);
  endfunction

endpackage

// File: rtl/agc_seq_timer.sv
// Saturating up-counter with terminal-count compare against a runtime limit.
module agc_seq_timer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 at_zero,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] cnt;

  // Holds at all-ones instead of wrapping so an idle HOLD never fakes a terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign at_zero = (cnt == '0);
  assign tc      = en && (limit != '0) && (cnt == (limit - CNT_WIDTH'(1)));

endmodule

// File: rtl/agc_seq_ctrl.sv
// AGC sequencer: settle, measure peak, commit gain, hold and periodically re-measure.
module agc_seq_ctrl
  import agc_seq_pkg::*;
#(
  parameter int                   CNT_WIDTH    = 32,
  parameter logic [CNT_WIDTH-1:0] SETTLE_CYC   = CNT_WIDTH'(1800),
  parameter logic [CNT_WIDTH-1:0] MEAS_TIMEOUT = CNT_WIDTH'(65536),
  parameter logic [CNT_WIDTH-1:0] REFRESH_CYC  = CNT_WIDTH'(1800000)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               retune,
  input  logic               meas_dready,
  input  logic               meas_const,
  output logic               meas_trig,
  output logic               cal_trig,
  output logic               gain_valid,
  output logic               busy,
  output logic               timeout_err,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0]   nxt;
  logic                 cnt_clr, cnt_en, cnt_zero, cnt_tc;
  logic [CNT_WIDTH-1:0] cnt_limit;
  logic                 gv_set, gv_clr, to_set, to_clr, restart;

  agc_seq_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .limit   (cnt_limit),
    .at_zero (cnt_zero),
    .tc      (cnt_tc)
  );

  always_comb begin
    nxt       = state;
    cnt_en    = 1'b0;
    cnt_limit = '0;
    gv_set    = 1'b0;
    gv_clr    = 1'b0;
    to_set    = 1'b0;
    to_clr    = 1'b0;
    restart   = 1'b0;
    case (state)
      ST_SETTLE:    begin cnt_en = 1'b1; cnt_limit = SETTLE_CYC;   end
      ST_MEAS_WAIT: begin cnt_en = 1'b1; cnt_limit = MEAS_TIMEOUT; end
      ST_HOLD:      begin cnt_en = 1'b1; cnt_limit = REFRESH_CYC;  end
      default:      ;
    endcase

    if (!enable) begin
      nxt    = ST_IDLE;
      gv_clr = 1'b1;
    end else if (retune && (state != ST_IDLE)) begin
      nxt     = ST_SETTLE;
      restart = 1'b1;
      gv_clr  = 1'b1;
      to_clr  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          nxt    = ST_SETTLE;
          to_clr = 1'b1;
        end
        ST_SETTLE:     if (cnt_tc) nxt = ST_MEAS_START;
        ST_MEAS_START: nxt = ST_MEAS_WAIT;
        // The dready level seen on the first wait cycle still belongs to the previous window.
        ST_MEAS_WAIT: begin
          if (meas_dready && !cnt_zero) begin
            nxt = meas_const ? ST_HOLD : ST_CAL;
          end else if (cnt_tc) begin
            nxt    = ST_MEAS_START;
            to_set = 1'b1;
          end
        end
        ST_CAL: begin
          nxt    = ST_HOLD;
          gv_set = 1'b1;
        end
        ST_HOLD:       if (cnt_tc) nxt = ST_MEAS_START;
        default:       nxt = ST_IDLE;
      endcase
    end

    cnt_clr = (nxt != state) || restart;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gain_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      if (gv_clr)      gain_valid <= 1'b0;
      else if (gv_set) gain_valid <= 1'b1;
      if (to_clr)      timeout_err <= 1'b0;
      else if (to_set) timeout_err <= 1'b1;
    end
  end

  // Triggers decode the state register only, so the reset truncates them immediately.
  assign meas_trig = (state == ST_MEAS_START);
  assign cal_trig  = (state == ST_CAL);
  assign busy      = is_busy(state);

endmodule

// File: tb/tb_agc_seq_ctrl.sv
// Bench for agc_seq_ctrl: elapsed-time reference model, per-cycle compare, literal timing pins.
module tb_agc_seq_ctrl;

  localparam int SET = 4;
  localparam int TMO = 20;
  localparam int REF = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       retune = 1'b0;
  logic       meas_dready = 1'b0;
  logic       meas_const = 1'b0;
  logic       meas_trig, cal_trig, gain_valid, busy, timeout_err;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  agc_seq_ctrl #(
    .CNT_WIDTH    (32),
    .SETTLE_CYC   (32'd4),
    .MEAS_TIMEOUT (32'd20),
    .REFRESH_CYC  (32'd50)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .retune      (retune),
    .meas_dready (meas_dready),
    .meas_const  (meas_const),
    .meas_trig   (meas_trig),
    .cal_trig    (cal_trig),
    .gain_valid  (gain_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .state       (state)
  );

  // Reference: the phase the block is in and the cycle it entered that phase.
  int cyc, m_st, m_entry, el, nx;
  bit m_gv, m_to, reent;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_st = 0; m_entry = 0; m_gv = 0; m_to = 0;
    end else begin
      el = cyc - m_entry;
      nx = m_st;
      reent = 0;
      if (!enable) begin
        nx = 0; m_gv = 0;
      end else if (retune && m_st != 0) begin
        nx = 1; reent = 1; m_gv = 0; m_to = 0;
      end else if (m_st == 0) begin
        nx = 1; m_to = 0;
      end else if (m_st == 1) begin
        if (el == SET - 1) nx = 2;
      end else if (m_st == 2) begin
        nx = 3;
      end else if (m_st == 3) begin
        if (el > 0 && meas_dready) nx = meas_const ? 5 : 4;
        else if (el == TMO - 1) begin nx = 2; m_to = 1; end
      end else if (m_st == 4) begin
        nx = 5; m_gv = 1;
      end else begin
        if (el == REF - 1) nx = 2;
      end
      cyc = cyc + 1;
      if (nx != m_st || reent) m_entry = cyc;
      m_st = nx;
    end
  end

  function automatic logic [7:0] exp_vec();
    return {3'(m_st), m_st == 2, m_st == 4, m_gv, (m_st >= 1 && m_st <= 4), m_to};
  endfunction

  function automatic logic [7:0] act_vec();
    return {state, meas_trig, cal_trig, gain_valid, busy, timeout_err};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    int g = 0;
    while (cyc < n && g < 1000) begin
      step();
      g++;
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL reach_cycle actual=%0d required=%0d", cyc, n);
    end
  endtask

  task automatic at(input int n);
    go_to(n);
    @(negedge clk);
  endtask

  task automatic pulse_dready(input logic c);
    meas_dready = 1'b1;
    meas_const  = c;
    step();
    meas_dready = 1'b0;
    meas_const  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        chk("model", act_vec(), exp_vec());
      end
      begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog actual=running required=done");
      end
      begin
        #12;
        chk("reset_state", act_vec(), 8'h00);
        #10 rst_n = 1'b1;

        go_to(10); enable = 1'b1;
        at(15);
        chk("first_meas_trig", 8'(meas_trig), 8'd1);
        go_to(23); pulse_dready(1'b0);
        chk("cal_trig_24", 8'(cal_trig), 8'd1);
        at(25);
        chk("gain_valid_25", 8'(gain_valid), 8'd1);
        chk("hold_25", 8'(state), 8'd5);
        at(74);
        chk("no_refresh_74", 8'(meas_trig), 8'd0);
        at(75);
        chk("refresh_75", 8'(meas_trig), 8'd1);

        go_to(80); pulse_dready(1'b1);
        chk("const_hold", 8'(state), 8'd5);
        chk("const_no_cal", 8'(cal_trig), 8'd0);
        chk("const_gv_kept", 8'(gain_valid), 8'd1);

        at(131);
        chk("tmo_m", 8'(meas_trig), 8'd1);
        at(151);
        chk("tmo_not_yet", 8'(timeout_err), 8'd0);
        at(152);
        chk("tmo_err", 8'(timeout_err), 8'd1);
        chk("tmo_retry", 8'(meas_trig), 8'd1);
        go_to(160); pulse_dready(1'b0);
        chk("retry_cal", 8'(cal_trig), 8'd1);
        at(162);
        chk("retry_sticky", 8'(timeout_err), 8'd1);
        chk("retry_gv", 8'(gain_valid), 8'd1);

        go_to(215);
        retune = 1'b1; meas_dready = 1'b1;
        step();
        retune = 1'b0; meas_dready = 1'b0;
        @(negedge clk);
        chk("retune_settle", 8'(state), 8'd1);
        chk("retune_gv", 8'(gain_valid), 8'd0);
        chk("retune_no_cal", 8'(cal_trig), 8'd0);
        chk("retune_to_clr", 8'(timeout_err), 8'd0);
        at(220);
        chk("retune_meas", 8'(meas_trig), 8'd1);

        go_to(225); pulse_dready(1'b0);
        chk("cal_226", 8'(cal_trig), 8'd1);
        enable = 1'b0;
        at(227);
        chk("drop_idle", act_vec(), 8'h00);

        go_to(230); enable = 1'b1;
        go_to(240); pulse_dready(1'b1);
        chk("const_first_hold", 8'(state), 8'd5);
        chk("const_first_gv", 8'(gain_valid), 8'd0);
        at(312);
        chk("tmo2_err", 8'(timeout_err), 8'd1);
        go_to(315); enable = 1'b0;
        at(316);
        chk("idle_sticky", 8'(timeout_err), 8'd1);
        go_to(320); enable = 1'b1;
        at(321);
        chk("enable_clr_to", 8'(timeout_err), 8'd0);

        go_to(325);
        chk("pre_rst_meas", 8'(meas_trig), 8'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_in_meas_start", act_vec(), 8'h00);
        #20 rst_n = 1'b1;
        at(1);
        chk("restart_settle", 8'(state), 8'd1);
        at(5);
        chk("restart_meas", 8'(meas_trig), 8'd1);
        go_to(10); pulse_dready(1'b0);
        at(12);
        chk("hold_before_rst", 8'(gain_valid), 8'd1);
        go_to(14);
        #1 rst_n = 1'b0;
        #1 chk("rst_in_hold", act_vec(), 8'h00);
        #20 rst_n = 1'b1;
        at(5);
        chk("restart2_meas", 8'(meas_trig), 8'd1);

        repeat (3000) begin
          step();
          enable      = ($urandom_range(0, 99) != 0);
          retune      = ($urandom_range(0, 199) == 0);
          meas_dready = ($urandom_range(0, 9) == 0);
          meas_const  = ($urandom_range(0, 3) == 0);
        end
        step();
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
